// File: rtl/gate_io_pkg.sv
// gate_io_pkg: shared types and constants for the gate input conditioning blocks
package gate_io_pkg;
  typedef enum logic {STABLE, COUNTING} db_state_t;
  localparam int DB_SYNC_STAGES = 2;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: two-flop synchroniser plus stable-count debounce for one raw input
module debounce_channel
  import gate_io_pkg::*;
#(
  parameter int STABLE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic upd,
  output logic counting
);
  localparam int W = $clog2(STABLE_CYCLES);
  localparam logic [W-1:0] LAST = W'(STABLE_CYCLES - 1);
  logic [DB_SYNC_STAGES-1:0] sync;
  logic s;
  db_state_t state, state_n;
  logic [W-1:0] cnt, cnt_n;
  logic clean_n;
  assign s = sync[DB_SYNC_STAGES-1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync  <= '0;
      state <= STABLE;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      sync  <= {sync[DB_SYNC_STAGES-2:0], raw};
      state <= state_n;
      cnt   <= cnt_n;
      clean <= clean_n;
    end
  // a sample matching clean while counting drops the count, so bounces restart from zero
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    clean_n = clean;
    if (state == STABLE) begin
      if (s != clean) begin
        state_n = COUNTING;
        cnt_n   = W'(1);
      end
    end else if (s == clean) begin
      state_n = STABLE;
    end else if (cnt == LAST) begin
      state_n = STABLE;
      clean_n = s;
    end else begin
      cnt_n = cnt + 1'b1;
    end
  end
  always_comb begin
    counting = state == COUNTING;
    upd      = counting && s != clean && cnt == LAST;
  end
endmodule

// File: rtl/gate_input_debouncer.sv
// gate_input_debouncer: conditions raw A/B gate inputs and strobes changed when either clean value updates
module gate_input_debouncer #(
  parameter int STABLE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_clean,
  output logic b_clean,
  output logic changed,
  output logic busy
);
  logic a_upd, b_upd, a_counting, b_counting;
  debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES)) u_a (
    .clk(clk), .rst_n(rst_n), .raw(a_raw),
    .clean(a_clean), .upd(a_upd), .counting(a_counting)
  );
  debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES)) u_b (
    .clk(clk), .rst_n(rst_n), .raw(b_raw),
    .clean(b_clean), .upd(b_upd), .counting(b_counting)
  );
  // registered on the same edge as clean, so the strobe lines up with the new value
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) changed <= 1'b0;
    else changed <= a_upd | b_upd;
  assign busy = a_counting | b_counting;
endmodule

// File: tb/tb_gate_input_debouncer.sv
// tb_gate_input_debouncer: directed checks of sync, debounce, glitch/bounce rejection and reset
module tb_gate_input_debouncer;
  logic clk = 1'b0;
  logic rst_n, a_raw, b_raw;
  logic a_clean, b_clean, changed, busy;
  int errs = 0;
  int checks = 0;

  gate_input_debouncer #(.STABLE_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .a_raw(a_raw), .b_raw(b_raw),
    .a_clean(a_clean), .b_clean(b_clean), .changed(changed), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_a_clean", a_clean, 0);
    chk("rst_b_clean", b_clean, 0);
    chk("rst_changed", changed, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int pulses;
    logic saw_chg, saw_busy;
    rst_n = 1'b0;
    a_raw = 1'b0;
    b_raw = 1'b0;
    step(3);
    chk("init_a_clean", a_clean, 0);
    chk("init_b_clean", b_clean, 0);
    chk("init_changed", changed, 0);
    chk("init_busy", busy, 0);
    rst_n = 1'b1;
    step(1);

    a_raw = 1'b1;
    step(9);
    chk("step_a_early", a_clean, 0);
    chk("step_busy", busy, 1);
    step(1);
    chk("step_a_rise", a_clean, 1);
    chk("step_changed", changed, 1);
    chk("step_b_hold", b_clean, 0);
    step(1);
    chk("step_changed_1cyc", changed, 0);
    chk("step_busy_done", busy, 0);

    b_raw = 1'b1;
    step(5);
    b_raw = 1'b0;
    saw_chg = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      saw_chg |= changed;
      saw_busy |= busy;
      step(1);
    end
    chk("glitch_b_clean", b_clean, 0);
    chk("glitch_no_changed", saw_chg, 0);
    chk("glitch_busy_seen", saw_busy, 1);
    chk("glitch_busy_end", busy, 0);
    chk("glitch_a_hold", a_clean, 1);

    a_raw = 1'b0;
    step(12);
    chk("fall_a_clean", a_clean, 0);
    a_raw = 1'b1; step(1);
    a_raw = 1'b0; step(1);
    a_raw = 1'b1; step(1);
    a_raw = 1'b0; step(1);
    a_raw = 1'b1;
    step(9);
    chk("bounce_a_early", a_clean, 0);
    step(1);
    chk("bounce_a_rise", a_clean, 1);
    chk("bounce_changed", changed, 1);

    a_raw = 1'b0;
    step(12);
    chk("pre_sim_a", a_clean, 0);
    a_raw = 1'b1;
    b_raw = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (changed) pulses++;
      if (i == 9) begin
        chk("sim_a_early", a_clean, 0);
        chk("sim_b_early", b_clean, 0);
      end
      if (i == 10) begin
        chk("sim_a_rise", a_clean, 1);
        chk("sim_b_rise", b_clean, 1);
      end
    end
    chk("sim_pulses", pulses[7:0], 1);

    pulse_reset();
    step(6);
    chk("midrst_busy", busy, 1);
    pulse_reset();
    step(9);
    chk("midrst_a_early", a_clean, 0);
    step(1);
    chk("midrst_a_rise", a_clean, 1);
    chk("midrst_b_rise", b_clean, 1);
    chk("midrst_changed", changed, 1);
    step(1);
    chk("midrst_changed_1cyc", changed, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
